sram_controller: RTL and testbench

//  Bridges the ARM MEM stage's 32-bit load/store requests to the 16-bit external SRAM (18-bit half-word address).

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_addr_map.sv | 34 +++
 rtl/sram_controller.sv | 184 ++++++++++++++++++
 tb/tb_sram_controller.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
//   Shared definitions for the 32-bit to 16-bit SRAM bridge: controller state
//   encoding, default geometry parameters and a small state-decode helper.
//   No ports (package).

package sram_ctrl_pkg;

    localparam int BASE_ADDR_DEF = 1024;
    localparam int SRAM_AW_DEF   = 18;

    typedef enum logic [2:0] {
        IDLE,
        WR_TURN,
        WR_HI,
        WR_LO,
        RD_LO,
        RD_HI,
        RD_CAP,
        DONE
    } state_t;

    function automatic logic is_write_state(input state_t s);
        return (s == WR_TURN) || (s == WR_HI) || (s == WR_LO);
    endfunction

endpackage

// File: rtl/sram_addr_map.sv
// sram_addr_map
//   Maps a word-aligned byte address from the MEM stage onto the pair of
//   SRAM half-word addresses that hold that word (low half even, high half odd).
//   Address bits above the SRAM range are dropped, so the map aliases.
// Ports
//   address  in   32          byte address
//   word     out  SRAM_AW-1   word index inside the SRAM
//   addr_lo  out  SRAM_AW     half-word address of bits [15:0]
//   addr_hi  out  SRAM_AW     half-word address of bits [31:16]

module sram_addr_map
    import sram_ctrl_pkg::*;
#(
    parameter int BASE_ADDR = BASE_ADDR_DEF,
    parameter int SRAM_AW   = SRAM_AW_DEF
) (
    input  logic [31:0]        address,
    output logic [SRAM_AW-2:0] word,
    output logic [SRAM_AW-1:0] addr_lo,
    output logic [SRAM_AW-1:0] addr_hi
);

    logic [31:0] offset;
    logic        unused_offset_bits;

    assign offset  = address - 32'(BASE_ADDR);
    assign word    = offset[SRAM_AW:2];
    assign addr_lo = {word, 1'b0};
    assign addr_hi = {word, 1'b1};

    // Byte-lane bits are zero for aligned words; top bits alias by design.
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

endmodule

// File: rtl/sram_controller.sv
// sram_controller
//   Bridges 32-bit loads/stores from the MEM stage to a 16-bit synchronous
//   SRAM. Each word is moved as two half-word accesses; ready stays low while
//   an access is in flight so the pipeline stalls. Requests, address and data
//   are not latched: the MEM stage holds them until ready is seen high.
//   Optional macro SRAM_LAST_WORD_CACHE_EN adds a one-entry write-through
//   cache of the last word loaded or stored; a load hit completes in one cycle
//   without touching the SRAM.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   wr_en, rd_en        store / load request (store wins if both)
//   address             byte address, word aligned
//   write_data          store data
//   read_data           load data, held until the next load
//   ready               access complete / controller free
//   SRAM_DQ             bidirectional half-word bus, driven only while writing
//   SRAM_ADDR           half-word address
//   SRAM_WE_N           write strobe, low in write states
//   SRAM_UB_N/LB_N/CE_N/OE_N   permanently enabled
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request
// WR_TURN | bus turnaround; low half driven, result rewritten in WR_LO
// WR_HI   | write high half at odd address
// WR_LO   | write low half at even address
// RD_LO   | present even address, SRAM registers low half
// RD_HI   | capture low half, present odd address
// RD_CAP  | capture high half
// DONE    | ready high for one cycle, then back to IDLE

module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int BASE_ADDR = BASE_ADDR_DEF,
    parameter int SRAM_AW   = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    inout  wire logic [15:0]   SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    state_t              state_q;
    state_t              state_d;
    logic [SRAM_AW-2:0]  word;
    logic [SRAM_AW-1:0]  addr_lo;
    logic [SRAM_AW-1:0]  addr_hi;
    logic [SRAM_AW-1:0]  addr_q;
    logic                dq_oe;
    logic [15:0]         dq_out;
    logic                cache_hit;
    logic [31:0]         hit_data;

    sram_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .address (address),
        .word    (word),
        .addr_lo (addr_lo),
        .addr_hi (addr_hi)
    );

`ifdef SRAM_LAST_WORD_CACHE_EN
    logic               cache_valid;
    logic [SRAM_AW-2:0] cache_word;
    logic [31:0]        cache_data;

    // Stores win over loads, so a hit only counts for a pure load.
    assign cache_hit = rd_en & ~wr_en & cache_valid & (cache_word == word);
    assign hit_data  = cache_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
        end else if (state_q == WR_LO) begin
            cache_valid <= 1'b1;
            cache_word  <= word;
            cache_data  <= write_data;
        end else if (state_q == RD_CAP) begin
            cache_valid <= 1'b1;
            cache_word  <= word;
            cache_data  <= {SRAM_DQ, read_data[15:0]};
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    state_d = WR_TURN;
                end else if (cache_hit) begin
                    state_d = DONE;
                end else if (rd_en) begin
                    state_d = RD_LO;
                end
            end
            WR_TURN: state_d = WR_HI;
            WR_HI:   state_d = WR_LO;
            WR_LO:   state_d = DONE;
            RD_LO:   state_d = RD_HI;
            RD_HI:   state_d = RD_CAP;
            RD_CAP:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outside active states the address bus parks on its last value, so a
    // cache hit leaves the SRAM pins untouched.
    always_comb begin
        ready     = 1'b0;
        SRAM_WE_N = ~is_write_state(state_q);
        dq_oe     = is_write_state(state_q);
        dq_out    = write_data[15:0];
        SRAM_ADDR = addr_q;
        case (state_q)
            IDLE:    ready = ~(wr_en | rd_en);
            WR_TURN: SRAM_ADDR = addr_lo;
            WR_HI: begin
                SRAM_ADDR = addr_hi;
                dq_out    = write_data[31:16];
            end
            WR_LO:   SRAM_ADDR = addr_lo;
            RD_LO:   SRAM_ADDR = addr_lo;
            RD_HI:   SRAM_ADDR = addr_hi;
            DONE:    ready = 1'b1;
            default: ;
        endcase
    end

    // The SRAM output is registered, so each half arrives one cycle after its
    // address was presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            read_data <= '0;
        end else begin
            addr_q <= SRAM_ADDR;
            case (state_q)
                IDLE: begin
                    if (cache_hit) begin
                        read_data <= hit_data;
                    end
                end
                RD_HI:   read_data[15:0]  <= SRAM_DQ;
                RD_CAP:  read_data[31:16] <= SRAM_DQ;
                default: ;
            endcase
        end
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//   Drives sram_controller against a synchronous 16-bit SRAM model whose
//   output driver releases the bus one cycle after SRAM_WE_N falls. A word
//   level reference memory plus a last-word record predict read data and
//   ready latency. A pull-up on the data bus makes a released bus read 0xFFFF.

module tb_sram_controller;

    localparam bit CACHE_ON =
`ifdef SRAM_LAST_WORD_CACHE_EN
        1'b1;
`else
        1'b0;
`endif

    localparam int LAT_FULL = 4;   // request cycle + three busy cycles
    localparam int LAT_HIT  = 1;   // request cycle only

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_oe_n;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_OE_N  (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model
    logic [15:0] sram_mem [0:(1<<18)-1];
    logic [15:0] sram_q;
    logic        prev_we_n;
    logic        drv_en;

    pullup (sram_dq);
    assign sram_dq = (drv_en && prev_we_n) ? sram_q : 16'bz;

    always @(posedge clk) begin
        prev_we_n <= sram_we_n;
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
        else            sram_q <= sram_mem[sram_addr];
    end

    // Reference model
    logic [31:0] ref_mem [int];
    logic [31:0] ref_rd;
    bit          cache_v;
    int          cache_w;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off / 32'd4) % 32'h20000);
    endfunction

    function automatic int exp_lat(input bit is_load, input int w);
        if (is_load && CACHE_ON && cache_v && cache_w == w) return LAT_HIT;
        return LAT_FULL;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        ref_mem[word_of(a)] = d;
        cache_v = 1'b1;
        cache_w = word_of(a);
    endtask

    task automatic model_load(input logic [31:0] a);
        ref_rd  = ref_mem.exists(word_of(a)) ? ref_mem[word_of(a)] : 32'h0;
        cache_v = 1'b1;
        cache_w = word_of(a);
    endtask

    task automatic model_reset();
        cache_v = 1'b0;
        ref_rd  = 32'h0;
    endtask

    // One request held until ready; lowcnt counts ready-low cycles.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [31:0] d, output int lowcnt,
                             output logic [31:0] rdata, output logic moved);
        logic [17:0] a0;
        @(posedge clk); #1;
        a0 = sram_addr;
        wr_en = wr; rd_en = rd; address = a; write_data = d;
        lowcnt = 0;
        moved  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_addr !== a0) moved = 1'b1;
            if (ready === 1'b1) break;
            lowcnt++;
        end
        rdata = read_data;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        drv_en = 1'b0;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd1024; write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready);
        else n_pass++;
        n_checks++;
        if (read_data !== 32'h0) $display("FAIL reset_read_data: got %h expected 0", read_data);
        else n_pass++;
        n_checks++;
        if (sram_we_n !== 1'b1) $display("FAIL reset_we_n: got %b expected 1", sram_we_n);
        else n_pass++;
        n_checks++;
        if (sram_dq !== 16'hFFFF) $display("FAIL reset_dq_released: got %h expected ffff", sram_dq);
        else n_pass++;
        n_checks++;
        if (sram_addr !== 18'h0) $display("FAIL reset_addr: got %h expected 0", sram_addr);
        else n_pass++;
        n_checks++;
        if ({sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n} !== 4'b0000)
            $display("FAIL tied_enables: got %b expected 0000",
                     {sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n});
        else n_pass++;
        drv_en = 1'b1;
    endtask

    task automatic test_store_load();
        int lat; int e; logic [31:0] rd; logic mv;
        e = exp_lat(1'b0, word_of(32'd1024));
        do_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lat, rd, mv);
        model_store(32'd1024, 32'hDEADBEEF);
        n_checks++;
        if (lat !== e) $display("FAIL store_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (sram_mem[0] !== 16'hBEEF) $display("FAIL sram_lo_half: got %h expected beef", sram_mem[0]);
        else n_pass++;
        n_checks++;
        if (sram_mem[1] !== 16'hDEAD) $display("FAIL sram_hi_half: got %h expected dead", sram_mem[1]);
        else n_pass++;
        e = exp_lat(1'b1, word_of(32'd1024));
        model_load(32'd1024);
        do_access(1'b0, 1'b1, 32'd1024, 32'h0, lat, rd, mv);
        n_checks++;
        if (lat !== e) $display("FAIL load_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (rd !== ref_rd) $display("FAIL load_data: got %h expected %h", rd, ref_rd);
        else n_pass++;
    endtask

    task automatic test_no_cross();
        int lat; int e; logic [31:0] rd; logic mv;
        do_access(1'b1, 1'b0, 32'd1028, 32'h12345678, lat, rd, mv);
        model_store(32'd1028, 32'h12345678);
        do_access(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, lat, rd, mv);
        model_store(32'd1032, 32'hCAFEF00D);
        e = exp_lat(1'b1, word_of(32'd1028));
        model_load(32'd1028);
        do_access(1'b0, 1'b1, 32'd1028, 32'h0, lat, rd, mv);
        n_checks++;
        if (lat !== e) $display("FAIL cross_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (rd !== ref_rd) $display("FAIL cross_data: got %h expected %h", rd, ref_rd);
        else n_pass++;
        n_checks++;
        if ({sram_mem[5], sram_mem[4]} !== 32'hCAFEF00D)
            $display("FAIL cross_neighbour: got %h expected cafef00d", {sram_mem[5], sram_mem[4]});
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int lat; int e; logic [31:0] rd; logic mv;
        e = exp_lat(1'b0, word_of(32'd1036));
        do_access(1'b1, 1'b1, 32'd1036, 32'hA5A55A5A, lat, rd, mv);
        n_checks++;
        if (lat !== e) $display("FAIL both_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (rd !== ref_rd) $display("FAIL both_read_data_held: got %h expected %h", rd, ref_rd);
        else n_pass++;
        model_store(32'd1036, 32'hA5A55A5A);
        e = exp_lat(1'b1, word_of(32'd1036));
        model_load(32'd1036);
        do_access(1'b0, 1'b1, 32'd1036, 32'h0, lat, rd, mv);
        n_checks++;
        if (lat !== e) $display("FAIL both_load_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (rd !== ref_rd) $display("FAIL both_load_data: got %h expected %h", rd, ref_rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        int lat; int e; int w; logic [31:0] rd; logic mv;
        w = word_of(32'd1040);
        @(posedge clk); #1;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'd1040; write_data = 32'h11112222;
        @(posedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (sram_addr !== 18'(2 * w + 1) || sram_we_n !== 1'b0)
            $display("FAIL mid_write_hi_phase: got addr %h we_n %b expected addr %h we_n 0",
                     sram_addr, sram_we_n, 18'(2 * w + 1));
        else n_pass++;
        rst = 1'b1; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem.delete(w);
        model_reset();
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1) $display("FAIL abort_ready: got %b expected 1", ready);
        else n_pass++;
        n_checks++;
        if (sram_we_n !== 1'b1) $display("FAIL abort_we_n: got %b expected 1", sram_we_n);
        else n_pass++;
        n_checks++;
        if (sram_dq !== 16'hFFFF) $display("FAIL abort_dq_released: got %h expected ffff", sram_dq);
        else n_pass++;
        n_checks++;
        if (read_data !== 32'h0) $display("FAIL abort_read_data: got %h expected 0", read_data);
        else n_pass++;
        do_access(1'b1, 1'b0, 32'd1040, 32'h33334444, lat, rd, mv);
        model_store(32'd1040, 32'h33334444);
        e = exp_lat(1'b1, w);
        model_load(32'd1040);
        do_access(1'b0, 1'b1, 32'd1040, 32'h0, lat, rd, mv);
        n_checks++;
        if (lat !== e) $display("FAIL abort_reload_latency: got %0d expected %0d", lat, e);
        else n_pass++;
        n_checks++;
        if (rd !== ref_rd) $display("FAIL abort_reload_data: got %h expected %h", rd, ref_rd);
        else n_pass++;
    endtask

    task automatic test_repeat_load();
        int lat; int e; logic [31:0] rd; logic mv; logic exp_mv;
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            e = exp_lat(1'b1, word_of(32'd1024));
            exp_mv = (e == LAT_HIT) ? 1'b0 : 1'b1;
            model_load(32'd1024);
            do_access(1'b0, 1'b1, 32'd1024, 32'h0, lat, rd, mv);
            n_checks++;
            if (lat !== e) $display("FAIL repeat_latency_%0d: got %0d expected %0d", k, lat, e);
            else n_pass++;
            n_checks++;
            if (rd !== ref_rd) $display("FAIL repeat_data_%0d: got %h expected %h", k, rd, ref_rd);
            else n_pass++;
            n_checks++;
            if (mv !== exp_mv) $display("FAIL repeat_addr_activity_%0d: got %b expected %b", k, mv, exp_mv);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int lat; int e; int w; int idx; int al; bit both;
        logic [31:0] a; logic [31:0] d; logic [31:0] rd; logic mv;
        for (int i = 0; i < 60; i++) begin
            idx = int'($urandom_range(0, 31));
            al  = int'($urandom_range(0, 3));
            a   = 32'd1024 + 32'(idx * 4) + (32'(al) << 19);
            w   = word_of(a);
            if (!ref_mem.exists(w) || $urandom_range(0, 1) == 0) begin
                d    = $urandom;
                both = ($urandom_range(0, 3) == 0);
                e    = exp_lat(1'b0, w);
                do_access(1'b1, both, a, d, lat, rd, mv);
                n_checks++;
                if (lat !== e) $display("FAIL rand_store_latency[%0d]: got %0d expected %0d", i, lat, e);
                else n_pass++;
                n_checks++;
                if (rd !== ref_rd) $display("FAIL rand_store_rd_held[%0d]: got %h expected %h", i, rd, ref_rd);
                else n_pass++;
                model_store(a, d);
            end else begin
                e = exp_lat(1'b1, w);
                model_load(a);
                do_access(1'b0, 1'b1, a, $urandom, lat, rd, mv);
                n_checks++;
                if (lat !== e) $display("FAIL rand_load_latency[%0d]: got %0d expected %0d", i, lat, e);
                else n_pass++;
                n_checks++;
                if (rd !== ref_rd) $display("FAIL rand_load_data[%0d] @%h: got %h expected %h", i, a, rd, ref_rd);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_no_cross();
        test_simultaneous();
        test_reset_mid_write();
        test_repeat_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
